// File: rtl/l1i_fill_ctrl.sv
// L1 instruction-cache miss controller: round-robin arbitration of per-thread misses, one L2 fill in flight.
// Optional L1I_MISS_MERGE_EN also wakes every thread waiting on the line being filled.
module l1i_fill_ctrl #(
    parameter int NUM_THREADS     = 4,
    parameter int LINE_ADDR_WIDTH = 26,
    parameter int SET_WIDTH       = 4,
    parameter int NUM_WAYS        = 4,
    parameter int LINE_BITS       = 512
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_THREADS-1:0]                 miss_valid,
    input  logic [NUM_THREADS*LINE_ADDR_WIDTH-1:0] miss_line_addr,
    output logic                                   l2_req_valid,
    input  logic                                   l2_req_ready,
    output logic [LINE_ADDR_WIDTH-1:0]             l2_req_addr,
    input  logic                                   l2_resp_valid,
    input  logic [LINE_BITS-1:0]                   l2_resp_data,
    input  logic [$clog2(NUM_WAYS)-1:0]            fill_victim_way,
    output logic                                   fill_en,
    output logic [$clog2(NUM_WAYS)-1:0]            fill_way,
    output logic [SET_WIDTH-1:0]                   fill_set,
    output logic [LINE_ADDR_WIDTH-SET_WIDTH-1:0]   fill_tag,
    output logic [LINE_BITS-1:0]                   fill_data,
    output logic [NUM_THREADS-1:0]                 wake_bitmap,
    output logic                                   busy
);

    localparam int TID_W = $clog2(NUM_THREADS);
    localparam int TAG_W = LINE_ADDR_WIDTH - SET_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FILL = 2'd3
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic [TID_W-1:0]           rr_ptr;
    logic [TID_W-1:0]           grant_id;
    logic [LINE_ADDR_WIDTH-1:0] line_addr;
    logic [LINE_BITS-1:0]       line_data;
    logic [NUM_THREADS-1:0]     wake_mask;
    logic [NUM_THREADS-1:0]     eligible;
    logic                       grant_found;
    logic [TID_W-1:0]           grant_next;
    logic [TID_W-1:0]           scan_idx;

    assign eligible = miss_valid & ~wake_mask;

    // Search from rr_ptr upward; power-of-two thread count makes the wrap free.
    always_comb begin
        grant_found = 1'b0;
        grant_next  = rr_ptr;
        scan_idx    = rr_ptr;
        for (int i = 0; i < NUM_THREADS; i++) begin
            scan_idx = rr_ptr + TID_W'(i);
            if (!grant_found && eligible[scan_idx]) begin
                grant_found = 1'b1;
                grant_next  = scan_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (grant_found)   state_next = S_REQ;
            S_REQ:  if (l2_req_ready)  state_next = S_WAIT;
            S_WAIT: if (l2_resp_valid) state_next = S_FILL;
            S_FILL:                    state_next = S_IDLE;
            default:                   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            grant_id  <= '0;
            line_addr <= '0;
            line_data <= '0;
            wake_mask <= '0;
        end else begin
            wake_mask <= wake_bitmap;
            if (state == S_IDLE && grant_found) begin
                grant_id  <= grant_next;
                line_addr <= miss_line_addr[grant_next*LINE_ADDR_WIDTH +: LINE_ADDR_WIDTH];
                rr_ptr    <= grant_next + TID_W'(1);
            end
            if (state == S_WAIT && l2_resp_valid) begin
                line_data <= l2_resp_data;
            end
        end
    end

    // Outputs are forced low while reset is held so a fill in progress is dropped without a wake.
    always_comb begin
        l2_req_valid = 1'b0;
        l2_req_addr  = '0;
        fill_en      = 1'b0;
        fill_way     = '0;
        fill_set     = '0;
        fill_tag     = '0;
        fill_data    = '0;
        wake_bitmap  = '0;
        busy         = 1'b0;
        if (!reset) begin
            busy = (state != S_IDLE);
            case (state)
                S_REQ: begin
                    l2_req_valid = 1'b1;
                    l2_req_addr  = line_addr;
                end
                S_FILL: begin
                    fill_en               = 1'b1;
                    fill_way              = fill_victim_way;
                    fill_set              = line_addr[SET_WIDTH-1:0];
                    fill_tag              = line_addr[LINE_ADDR_WIDTH-1:SET_WIDTH];
                    fill_data             = line_data;
                    wake_bitmap[grant_id] = 1'b1;
`ifdef L1I_MISS_MERGE_EN
                    for (int i = 0; i < NUM_THREADS; i++) begin
                        if (miss_valid[i] &&
                            miss_line_addr[i*LINE_ADDR_WIDTH +: LINE_ADDR_WIDTH] == line_addr) begin
                            wake_bitmap[i] = 1'b1;
                        end
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1i_fill_ctrl.sv
// Directed self-checking bench for l1i_fill_ctrl: single miss, round-robin, backpressure,
// same-line misses, reset during WAIT and stray responses.
module tb_l1i_fill_ctrl;

    localparam int NT = 4;
    localparam int AW = 26;
    localparam int LB = 512;

    logic            clk;
    logic            reset;
    logic [NT-1:0]   miss_valid;
    logic [NT*AW-1:0] miss_line_addr;
    logic            l2_req_valid;
    logic            l2_req_ready;
    logic [AW-1:0]   l2_req_addr;
    logic            l2_resp_valid;
    logic [LB-1:0]   l2_resp_data;
    logic [1:0]      fill_victim_way;
    logic            fill_en;
    logic [1:0]      fill_way;
    logic [3:0]      fill_set;
    logic [21:0]     fill_tag;
    logic [LB-1:0]   fill_data;
    logic [NT-1:0]   wake_bitmap;
    logic            busy;

    int compared;
    int mismatched;

    l1i_fill_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .miss_valid      (miss_valid),
        .miss_line_addr  (miss_line_addr),
        .l2_req_valid    (l2_req_valid),
        .l2_req_ready    (l2_req_ready),
        .l2_req_addr     (l2_req_addr),
        .l2_resp_valid   (l2_resp_valid),
        .l2_resp_data    (l2_resp_data),
        .fill_victim_way (fill_victim_way),
        .fill_en         (fill_en),
        .fill_way        (fill_way),
        .fill_set        (fill_set),
        .fill_tag        (fill_tag),
        .fill_data       (fill_data),
        .wake_bitmap     (wake_bitmap),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NT-1:0] mv, input logic rdy,
                                 input logic rv, input logic [1:0] way);
        miss_valid      = mv;
        l2_req_ready    = rdy;
        l2_resp_valid   = rv;
        fill_victim_way = way;
    endtask

    task automatic setAddr(input int t, input logic [AW-1:0] a);
        miss_line_addr[t*AW +: AW] = a;
    endtask

    task automatic checkOutput(input string tag, input logic [LB-1:0] observed,
                               input logic [LB-1:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".req_valid"}, LB'(l2_req_valid), LB'(0));
        checkOutput({tag, ".req_addr"},  LB'(l2_req_addr),  LB'(0));
        checkOutput({tag, ".fill_en"},   LB'(fill_en),      LB'(0));
        checkOutput({tag, ".fill_data"}, fill_data,         LB'(0));
        checkOutput({tag, ".wake"},      LB'(wake_bitmap),  LB'(0));
        checkOutput({tag, ".busy"},      LB'(busy),         LB'(0));
    endtask

    initial begin
        logic [LB-1:0] data_a;
        logic [LB-1:0] data_b;
        logic [LB-1:0] data_c;
        logic [NT-1:0] woken;
        compared   = 0;
        mismatched = 0;
        data_a = {16{32'hDEADBEEF}};
        data_b = {8{64'h0123456789ABCDEF}};
        data_c = {16{32'hA5A5_5A5A}};

        // Reset state.
        reset          = 1'b1;
        miss_line_addr = '0;
        l2_resp_data   = '0;
        applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0);
        tick();
        tick();
        checkIdle("reset");
        reset = 1'b0;
        tick();
        checkIdle("post_reset");

        // Single miss: thread 2, line 0x0000ABC.
        setAddr(2, 26'h0000ABC);
        applyStimulus(4'b0100, 1'b0, 1'b0, 2'd2);
        tick();
        checkOutput("single.req_valid", LB'(l2_req_valid), LB'(1));
        checkOutput("single.req_addr",  LB'(l2_req_addr),  LB'(26'h0000ABC));
        checkOutput("single.busy",      LB'(busy),         LB'(1));
        l2_req_ready = 1'b1;
        tick();
        checkOutput("single.wait_req", LB'(l2_req_valid), LB'(0));
        l2_req_ready = 1'b0;
        tick();
        checkOutput("single.wait_fill", LB'(fill_en), LB'(0));
        l2_resp_valid = 1'b1;
        l2_resp_data  = data_a;
        tick();
        checkOutput("single.fill_en",   LB'(fill_en),     LB'(1));
        checkOutput("single.fill_set",  LB'(fill_set),    LB'(4'hC));
        checkOutput("single.fill_tag",  LB'(fill_tag),    LB'(22'h00000AB));
        checkOutput("single.fill_way",  LB'(fill_way),    LB'(2'd2));
        checkOutput("single.fill_data", fill_data,        data_a);
        checkOutput("single.wake",      LB'(wake_bitmap), LB'(4'b0100));
        applyStimulus(4'b0000, 1'b0, 1'b0, 2'd2);
        tick();
        checkIdle("single.done");

        // Round-robin from a fresh pointer; each woken thread drops its miss one cycle late.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        setAddr(0, 26'h0000100);
        setAddr(1, 26'h0000211);
        setAddr(2, 26'h0000322);
        setAddr(3, 26'h0000433);
        applyStimulus(4'b1111, 1'b0, 1'b0, 2'd1);
        for (int k = 0; k < NT; k++) begin
            tick();
            checkOutput($sformatf("rr%0d.req_addr", k), LB'(l2_req_addr),
                        LB'(26'h0000100 + 26'(k) * 26'h111));
            l2_req_ready = 1'b1;
            tick();
            l2_req_ready  = 1'b0;
            l2_resp_valid = 1'b1;
            l2_resp_data  = data_b;
            tick();
            checkOutput($sformatf("rr%0d.wake", k), LB'(wake_bitmap), LB'(4'b0001 << k));
            checkOutput($sformatf("rr%0d.way", k),  LB'(fill_way),    LB'(2'd1));
            l2_resp_valid = 1'b0;
            tick();
            miss_valid[k] = 1'b0;
        end
        tick();
        checkIdle("rr.drained");

        // Pointer wrapped to 0: with threads 0 and 3 pending, thread 0 wins.
        miss_valid = 4'b1001;
        tick();
        checkOutput("rr.wrap_addr", LB'(l2_req_addr), LB'(26'h0000100));
        l2_req_ready = 1'b1;
        tick();
        l2_req_ready = 1'b0;

        // Reset while in WAIT, with a response arriving during and after reset.
        reset         = 1'b1;
        l2_resp_valid = 1'b1;
        l2_resp_data  = data_c;
        tick();
        checkIdle("rst_wait.during");
        reset      = 1'b0;
        miss_valid = 4'b0000;
        tick();
        checkIdle("rst_wait.stale1");
        tick();
        checkIdle("rst_wait.stale2");
        l2_resp_valid = 1'b0;

        // Backpressure with a stray response in IDLE and REQ; boundary all-ones address.
        setAddr(1, 26'h3FFFFFF);
        applyStimulus(4'b0010, 1'b0, 1'b1, 2'd3);
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp%0d.req_valid", i), LB'(l2_req_valid), LB'(1));
            checkOutput($sformatf("bp%0d.req_addr", i),  LB'(l2_req_addr),  LB'(26'h3FFFFFF));
            checkOutput($sformatf("bp%0d.fill_en", i),   LB'(fill_en),      LB'(0));
            tick();
        end
        checkOutput("bp5.req_valid", LB'(l2_req_valid), LB'(1));
        checkOutput("bp5.req_addr",  LB'(l2_req_addr),  LB'(26'h3FFFFFF));
        l2_req_ready  = 1'b1;
        l2_resp_valid = 1'b0;
        tick();
        l2_req_ready = 1'b0;
        checkOutput("bp.one_handshake", LB'(l2_req_valid), LB'(0));
        tick();
        checkOutput("bp.wait_hold", LB'(fill_en), LB'(0));
        l2_resp_valid = 1'b1;
        l2_resp_data  = data_a;
        tick();
        checkOutput("bp.fill_set",  LB'(fill_set),    LB'(4'hF));
        checkOutput("bp.fill_tag",  LB'(fill_tag),    LB'(22'h3FFFFF));
        checkOutput("bp.fill_way",  LB'(fill_way),    LB'(2'd3));
        checkOutput("bp.wake",      LB'(wake_bitmap), LB'(4'b0010));
        applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0);
        tick();
        checkIdle("bp.done");

        // Threads 0 and 3 miss on the same line.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        setAddr(0, 26'h1234567);
        setAddr(3, 26'h1234567);
        applyStimulus(4'b1001, 1'b0, 1'b0, 2'd0);
        tick();
        checkOutput("merge.req_addr", LB'(l2_req_addr), LB'(26'h1234567));
        l2_req_ready = 1'b1;
        tick();
        l2_req_ready  = 1'b0;
        l2_resp_valid = 1'b1;
        l2_resp_data  = data_c;
        tick();
        checkOutput("merge.fill_set", LB'(fill_set), LB'(4'h7));
        checkOutput("merge.fill_tag", LB'(fill_tag), LB'(22'h123456));
`ifdef L1I_MISS_MERGE_EN
        woken = 4'b1001;
`else
        woken = 4'b0001;
`endif
        checkOutput("merge.wake1", LB'(wake_bitmap), LB'(woken));
        l2_resp_valid = 1'b0;
        tick();
        miss_valid = miss_valid & ~woken;
        tick();
`ifdef L1I_MISS_MERGE_EN
        checkIdle("merge.no_second_req");
`else
        checkOutput("merge.req2_valid", LB'(l2_req_valid), LB'(1));
        checkOutput("merge.req2_addr",  LB'(l2_req_addr),  LB'(26'h1234567));
        l2_req_ready = 1'b1;
        tick();
        l2_req_ready  = 1'b0;
        l2_resp_valid = 1'b1;
        tick();
        checkOutput("merge.wake2", LB'(wake_bitmap), LB'(4'b1000));
        l2_resp_valid = 1'b0;
        miss_valid    = 4'b0000;
        tick();
        checkIdle("merge.done");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
